log10_share_ctrl: RTL and testbench

//   Shares one LOG10 CORDIC pipeline among N_REQ requesters (e.g. per-channel spectrum power bins).

---
 rtl/log10_share_ctrl_if.sv | 34 +++
 rtl/log10_share_ctrl.sv | 137 +++++++++++++
 tb/tb_log10_share_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/log10_share_ctrl_if.sv
`timescale 1ns/1ps
// Requester, LOG10 and result handshakes around the shared LOG10 controller.
// The controller connects through the master modport, its environment through the slave modport.
interface log10_share_ctrl_if #(
  parameter int N_REQ  = 4,
  parameter int DW_IN  = 41,
  parameter int DW_OUT = 18
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*DW_IN-1:0] req_data;

  logic                   log_en;
  logic [DW_IN-1:0]       log_din;
  logic                   log_oen;
  logic [DW_OUT-1:0]      log_dout;

  logic                   res_valid;
  logic                   res_ready;
  logic [DW_OUT-1:0]      res_data;
  logic [IDW-1:0]         res_id;

  modport master (
    input  req_valid, req_data, log_oen, log_dout, res_ready,
    output req_ready, log_en, log_din, res_valid, res_data, res_id
  );

  modport slave (
    output req_valid, req_data, log_oen, log_dout, res_ready,
    input  req_ready, log_en, log_din, res_valid, res_data, res_id
  );
endinterface

// File: rtl/log10_share_ctrl.sv
`timescale 1ns/1ps
// Round-robin sharing of one non-stallable LOG10 pipeline among N_REQ requesters.
// A credit check reserves a result-FIFO slot for every issued sample before it is issued.
module log10_share_ctrl #(
  parameter int N_REQ      = 4,
  parameter int LAT        = 18,
  parameter int FIFO_DEPTH = 32,
  parameter int DW_IN      = 41,
  parameter int DW_OUT     = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  log10_share_ctrl_if.master            bus,
  output logic [$clog2(FIFO_DEPTH):0]   inflight,
  output logic                          err_orphan
);
  localparam int IDW = $clog2(N_REQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RW  = IDW + DW_OUT;

  // LAT only sizes FIFO_DEPTH (>= LAT+2 keeps one issue per cycle); no logic here depends on it.
  logic lat_unused;
  assign lat_unused = (LAT >= 0);

  logic [IDW-1:0]   ptr_q;
  logic             log_en_q;
  logic [DW_IN-1:0] log_din_q;
  logic [CW-1:0]    inflight_q;
  logic             err_orphan_q;

  logic [IDW-1:0]   id_mem [FIFO_DEPTH];
  logic [AW-1:0]    id_wr_ptr, id_rd_ptr;

  logic [RW-1:0]    res_mem [FIFO_DEPTH];
  logic [AW-1:0]    res_wr_ptr, res_rd_ptr;
  logic [CW-1:0]    res_count_q;

  logic [CW:0]      credit_used;
  logic             can_issue;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   ptr_next;
  logic             accept;
  logic             ret;
  logic             orphan;
  logic             res_pop;
  logic             res_nonempty;

  // Both terms are registered, so grants never depend on res_ready in the same cycle.
  assign credit_used = {1'b0, inflight_q} + {1'b0, res_count_q};
  assign can_issue   = !rst && (credit_used < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    logic [IDW:0] cand;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    // Walk downward so the last hit, the one closest above ptr, wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (can_issue && bus.req_valid[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  assign bus.req_ready = grant_vld ? (N_REQ'(1) << grant_idx) : '0;

  assign accept       = grant_vld;
  assign ptr_next     = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign ret          = bus.log_oen && (inflight_q != '0);
  assign orphan       = bus.log_oen && (inflight_q == '0);
  assign res_nonempty = (res_count_q != '0);
  assign res_pop      = res_nonempty && bus.res_ready;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ptr_q        <= '0;
      log_en_q     <= 1'b0;
      log_din_q    <= '0;
      inflight_q   <= '0;
      err_orphan_q <= 1'b0;
      id_wr_ptr    <= '0;
      id_rd_ptr    <= '0;
      res_wr_ptr   <= '0;
      res_rd_ptr   <= '0;
      res_count_q  <= '0;
    end else begin
      log_en_q <= accept;
      if (accept) begin
        log_din_q <= bus.req_data[int'(grant_idx) * DW_IN +: DW_IN];
        ptr_q     <= ptr_next;
        id_wr_ptr <= id_wr_ptr + 1'b1;
      end
      if (ret) begin
        id_rd_ptr  <= id_rd_ptr + 1'b1;
        res_wr_ptr <= res_wr_ptr + 1'b1;
      end
      if (res_pop) res_rd_ptr <= res_rd_ptr + 1'b1;

      case ({accept, ret})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase

      // The credit rule bounds res_count_q by FIFO_DEPTH, so a push is never refused.
      case ({ret, res_pop})
        2'b10:   res_count_q <= res_count_q + 1'b1;
        2'b01:   res_count_q <= res_count_q - 1'b1;
        default: res_count_q <= res_count_q;
      endcase

      if (orphan) err_orphan_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; pointers and counts alone define which words are valid.
    if (accept) id_mem[id_wr_ptr] <= grant_idx;
    if (ret)    res_mem[res_wr_ptr] <= {id_mem[id_rd_ptr], bus.log_dout};
  end

  assign bus.log_en    = log_en_q;
  assign bus.log_din   = log_din_q;
  assign bus.res_valid = res_nonempty;
  assign bus.res_id    = res_mem[res_rd_ptr][RW-1 -: IDW];
  assign bus.res_data  = res_mem[res_rd_ptr][DW_OUT-1:0];
  assign inflight      = inflight_q;
  assign err_orphan    = err_orphan_q;

endmodule

// File: tb/tb_log10_share_ctrl.sv
`timescale 1ns/1ps
// Directed bench for log10_share_ctrl with an LAT-deep stand-in LOG10 pipeline and an
// in-order result scoreboard.
module tb_log10_share_ctrl;
  localparam int N_REQ      = 4;
  localparam int LAT        = 18;
  localparam int FIFO_DEPTH = 32;
  localparam int DW_IN      = 41;
  localparam int DW_OUT     = 18;

  logic clk;
  logic rst;
  logic [5:0] inflight;
  logic err_orphan;
  logic force_oen;

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;
  int n_pop    = 0;
  logic [19:0] sb [$];

  log10_share_ctrl_if #(.N_REQ(N_REQ), .DW_IN(DW_IN), .DW_OUT(DW_OUT)) bus ();

  log10_share_ctrl #(
    .N_REQ(N_REQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .DW_IN(DW_IN), .DW_OUT(DW_OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .inflight   (inflight),
    .err_orphan (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the CORDIC: any fixed mapping that differs from its input.
  function automatic logic [DW_OUT-1:0] log_model(input logic [DW_IN-1:0] x);
    return x[17:0] ^ x[35:18] ^ {13'd0, x[40:36]} ^ 18'h2A5A5;
  endfunction

  logic [LAT-1:0]    en_pipe;
  logic [DW_OUT-1:0] d_pipe [LAT];

  always_ff @(posedge clk) begin
    if (rst) en_pipe <= '0;
    else     en_pipe <= {en_pipe[LAT-2:0], bus.log_en};
    d_pipe[0] <= log_model(bus.log_din);
    for (int s = 1; s < LAT; s++) d_pipe[s] <= d_pipe[s-1];
  end

  assign bus.log_oen  = en_pipe[LAT-1] | force_oen;
  assign bus.log_dout = force_oen ? 18'h3FFFF : d_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand_data();
    for (int i = 0; i < N_REQ; i++)
      bus.req_data[i*DW_IN +: DW_IN] = DW_IN'({$urandom(), $urandom()});
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while ((sb.size() != 0 || bus.res_valid) && c < 300) begin
      tick();
      c++;
    end
    check({tag, "_left_in_flight"}, 64'(sb.size()), 64'd0);
    check({tag, "_inflight_zero"}, 64'(inflight), 64'd0);
  endtask

  // Scoreboard: record accepted samples, compare every popped result in order.
  always @(negedge clk) begin
    logic [19:0] exp_w;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        n_pop++;
        exp_w = (sb.size() != 0) ? sb.pop_front() : 20'hxxxxx;
        check("sb_result", 64'({bus.res_id, bus.res_data}), 64'(exp_w));
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back({2'(i), log_model(bus.req_data[i*DW_IN +: DW_IN])});
          n_accept++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int acc0;
    logic [3:0] exp_oh;
    logic [3:0] t4_valid [13];
    logic [3:0] t4_grant [13];

    rst = 1'b1;
    force_oen = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_log_en", 64'(bus.log_en), 64'd0);
    check("rst_log_din", 64'(bus.log_din), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    rst = 1'b0;

    // 1: single request from requester 2
    bus.res_ready = 1'b1;
    bus.req_data[2*DW_IN +: DW_IN] = 41'd1000;
    bus.req_valid = 4'b0100;
    #1;
    check("t1_grant", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    check("t1_log_en", 64'(bus.log_en), 64'd1);
    check("t1_log_din", 64'(bus.log_din), 64'd1000);
    check("t1_inflight", 64'(inflight), 64'd1);
    c = 0;
    do begin
      tick();
      c++;
      if (c == 1) check("t1_log_en_pulse", 64'(bus.log_en), 64'd0);
    end while (!bus.res_valid && c < 100);
    check("t1_latency", 64'(c), 64'(LAT + 1));
    check("t1_res_id", 64'(bus.res_id), 64'd2);
    check("t1_res_data", 64'(bus.res_data), 64'h2A64D);
    check("t1_inflight_back", 64'(inflight), 64'd0);
    tick();
    check("t1_res_popped", 64'(bus.res_valid), 64'd0);

    // 2: all four requesters continuously valid, starting from ptr 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N_REQ; i++)
        bus.req_data[i*DW_IN +: DW_IN] = DW_IN'(k * 100 + i + 1);
      #1;
      exp_oh = 4'b0001 << (k % 4);
      check("t2_grant", 64'(bus.req_ready), 64'(exp_oh));
      tick();
      check("t2_issue", 64'(bus.log_en), 64'd1);
    end
    bus.req_valid = '0;
    drain("t2");

    // 3: consumer stalled; credits must stop issue at FIFO_DEPTH
    bus.res_ready = 1'b0;
    acc0 = n_accept;
    bus.req_valid = 4'hF;
    repeat (60) begin
      set_rand_data();
      tick();
    end
    check("t3_accepts", 64'(n_accept - acc0), 64'(FIFO_DEPTH));
    check("t3_ready_blocked", 64'(bus.req_ready), 64'd0);
    check("t3_res_valid", 64'(bus.res_valid), 64'd1);
    check("t3_inflight", 64'(inflight), 64'd0);
    bus.res_ready = 1'b1;
    #1;
    check("t3_ready_indep_of_res_ready", 64'(bus.req_ready), 64'd0);
    tick();
    check("t3_issue_after_pop", 64'(bus.req_ready != '0), 64'd1);
    repeat (40) begin
      set_rand_data();
      tick();
    end
    bus.req_valid = '0;
    drain("t3");
    check("t3_no_loss_no_dup", 64'(n_pop), 64'(n_accept));

    // 4: sparse requesters, ptr from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t4_valid = '{4'b0010, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b1000, 4'b0000,
                 4'b0010, 4'b1010, 4'b0001, 4'b1011, 4'b1001, 4'b1001};
    t4_grant = '{4'b0010, 4'b1000, 4'b0000, 4'b0010, 4'b1000, 4'b1000, 4'b0000,
                 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
    for (int s = 0; s < 13; s++) begin
      bus.req_valid = t4_valid[s];
      set_rand_data();
      #1;
      check($sformatf("t4_grant_step%0d", s), 64'(bus.req_ready), 64'(t4_grant[s]));
      tick();
    end
    bus.req_valid = '0;
    drain("t4");

    // 5: orphan return with nothing in flight
    force_oen = 1'b1;
    tick();
    force_oen = 1'b0;
    check("t5_err_orphan_set", 64'(err_orphan), 64'd1);
    check("t5_res_valid", 64'(bus.res_valid), 64'd0);
    check("t5_inflight", 64'(inflight), 64'd0);
    repeat (3) tick();
    check("t5_err_orphan_sticky", 64'(err_orphan), 64'd1);

    // 6: reset with ten samples in flight
    bus.req_valid = 4'hF;
    repeat (10) begin
      set_rand_data();
      tick();
    end
    bus.req_valid = '0;
    repeat (3) tick();
    check("t6_inflight_before", 64'(inflight), 64'd10);
    check("t6_err_orphan_before", 64'(err_orphan), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_req_ready", 64'(bus.req_ready), 64'd0);
    check("t6_log_en", 64'(bus.log_en), 64'd0);
    check("t6_log_din", 64'(bus.log_din), 64'd0);
    check("t6_res_valid", 64'(bus.res_valid), 64'd0);
    check("t6_inflight", 64'(inflight), 64'd0);
    check("t6_err_orphan_cleared", 64'(err_orphan), 64'd0);
    for (int q = 0; q < LAT + 12; q++) begin
      tick();
      check("t6_no_stale_result", 64'(bus.res_valid), 64'd0);
    end
    bus.req_data[0 +: DW_IN] = 41'd5;
    bus.req_valid = 4'b0001;
    #1;
    check("t6_grant_after_rst", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
